// File: rtl/div16by8u_seq_pkg.sv
// Shared widths, iteration count and FSM state encoding for the 16/8 unsigned sequential divider.
package div_pkg;
   localparam int DIV_N_W   = 16;
   localparam int DIV_D_W   = 8;
   localparam int DIV_ITERS = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;
endpackage

// File: rtl/div16by8u_seq_if.sv
// Request/result handshake bundle for the divider; master issues operands and drains results.
interface div16by8u_seq_if;
   import div_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [DIV_N_W-1:0] dividend;
   logic [DIV_D_W-1:0] divisor;
   logic               out_valid;
   logic               out_ready;
   logic [DIV_N_W-1:0] quotient;
   logic [DIV_D_W-1:0] remainder;
   logic               div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div16by8u_seq_restore_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_restore_step
   import div_pkg::*;
(
   input  logic [DIV_D_W-1:0] rem,
   input  logic               bit_in,
   input  logic [DIV_D_W-1:0] divisor,
   output logic [DIV_D_W-1:0] rem_nxt,
   output logic               q_bit
);
   logic [DIV_D_W:0] r9;

   assign r9    = {rem, bit_in};
   assign q_bit = (r9 >= {1'b0, divisor});
   // Partial remainder stays below the divisor, so the low 8 bits of the difference are exact.
   assign rem_nxt = q_bit ? (r9[DIV_D_W-1:0] - divisor) : r9[DIV_D_W-1:0];
endmodule

// File: rtl/div16by8u_seq.sv
// 16/8 unsigned restoring divider: 16 cycles accept->out_valid, result held until out_ready, no overlap.
// DIV16BY8U_DIVZERO_FAST_EN: a zero divisor skips the iterations and goes straight to DONE.
module div16by8u_seq
   import div_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   div16by8u_seq_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_BUSY  = BUSY;
   localparam logic [1:0] ST_DONE  = DONE;
   localparam logic [3:0] CNT_LAST = 4'(DIV_ITERS - 1);

   logic [1:0]         state;
   logic [3:0]         cnt;
   logic [DIV_N_W-1:0] acc;
   logic [DIV_D_W-1:0] dsr;
   logic [DIV_D_W-1:0] rem;
   logic [DIV_D_W-1:0] rem_nxt;
   logic               q_bit;
   logic               dz;

   // acc shifts dividend bits out of the top while quotient bits enter at the bottom.
   div_restore_step u_step (
      .rem     (rem),
      .bit_in  (acc[DIV_N_W-1]),
      .divisor (dsr),
      .rem_nxt (rem_nxt),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         acc   <= '0;
         dsr   <= '0;
         rem   <= '0;
         dz    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  acc <= bus.dividend;
                  dsr <= bus.divisor;
                  rem <= '0;
                  cnt <= '0;
                  dz  <= (bus.divisor == '0);
`ifdef DIV16BY8U_DIVZERO_FAST_EN
                  if (bus.divisor == '0) begin
                     acc   <= '1;
                     rem   <= bus.dividend[DIV_D_W-1:0];
                     state <= ST_DONE;
                  end else begin
                     state <= ST_BUSY;
                  end
`else
                  state <= ST_BUSY;
`endif
               end
            end
            ST_BUSY: begin
               acc <= {acc[DIV_N_W-2:0], q_bit};
               rem <= rem_nxt;
               cnt <= cnt + 4'd1;
               if (cnt == CNT_LAST) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready    = (state == ST_IDLE);
   assign bus.out_valid   = (state == ST_DONE);
   assign bus.quotient    = acc;
   assign bus.remainder   = rem;
   assign bus.div_by_zero = dz;
endmodule
